// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// 16x-oversampling UART receiver.
//
// The sample-enable pulse rx_clk comes from the baud generator. The receiver
// deserialises 8N1 frames from the asynchronous serial line rx. Each received
// byte is offered to the consumer on a valid/ready handshake. Framing and
// overrun problems are reported as single-cycle pulses.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   When the macro is defined, one even-parity bit is expected between the
//   last data bit and the stop bit, and the extra output parity_err is
//   present. When the macro is undefined, frames are plain 8N1 and the
//   parity_err port does not exist.
//
// Parameters:
//   DATA_BITS   data bits per frame, received LSB first
//   OVERSAMPLE  rx_clk pulses per bit period (a power of two, at least 8)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_clk       active-low, one-clk-wide sample enable ("tick")
//   rx           serial line; idles high; asynchronous to clk
//   rx_data      received byte; stable while rx_valid is high
//   rx_valid     byte available; held until accepted
//   rx_ready     consumer accepts rx_data when rx_valid && rx_ready
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: byte dropped because the previous one
//                was still unaccepted
//   parity_err   (UART_RX_PARITY_EN only) one-cycle pulse on a parity
//                mismatch
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 overrun_err,
    output logic                 parity_err
`else
    output logic                 overrun_err
`endif
);

    // Counter widths: tick counter covers one bit period, bit counter covers
    // the data bits of one frame.
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Receiver states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tickCnt_q;
    logic [BW-1:0]          bitCnt_q;
    logic [DATA_BITS-1:0]   shiftReg_q;
    logic [DATA_BITS-1:0]   shiftReg_d;
    logic                   rxMeta_q;
    logic                   rxSync_q;
    logic                   stopSeen_q;
    logic                   stopBit_q;
    logic [DATA_BITS-1:0]   rxData_q;
    logic                   rxValid_q;
    logic                   frameErr_q;
    logic                   overrunErr_q;
`ifdef UART_RX_PARITY_EN
    logic                   parityBit_q;
    logic                   parityErr_q;
`endif
    logic                   tick;

    // rx_clk is active low: a tick is a clk edge with rx_clk == 0
    assign tick = ~rx_clk;

    // Right shift so that the first bit on the line ends up in the LSB
    assign shiftReg_d = {rxSync_q, shiftReg_q[DATA_BITS-1:1]};

    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign frame_err   = frameErr_q;
    assign overrun_err = overrunErr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parityErr_q;
`endif

    // Two-flop synchroniser for the asynchronous line. Both flops reset to
    // the idle level, so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receiver FSM, shift register, and output handshake.
    //
    // The stop-bit tick only records the stop sample in stopSeen_q and
    // stopBit_q. The handshake part acts on that record one clk later. That
    // is where the byte is loaded, the overrun is flagged, or the framing
    // error is flagged, and it keeps all output pulses aligned to the same
    // cycle. The handshake runs on every clk; everything else advances only
    // on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tickCnt_q    <= '0;
            bitCnt_q     <= '0;
            shiftReg_q   <= '0;
            stopSeen_q   <= 1'b0;
            stopBit_q    <= 1'b0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit_q  <= 1'b0;
            parityErr_q  <= 1'b0;
`endif
        end else begin
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
            stopSeen_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q  <= 1'b0;
`endif

            if (rxValid_q && rx_ready) begin
                rxValid_q <= 1'b0;
            end

            // A byte arriving on the same edge as an acceptance replaces the
            // old one. Without an acceptance, the new byte is dropped.
            if (stopSeen_q) begin
                if (stopBit_q) begin
                    if (!rxValid_q || rx_ready) begin
                        rxData_q  <= shiftReg_q;
                        rxValid_q <= 1'b1;
                    end else begin
                        overrunErr_q <= 1'b1;
                    end
                end else begin
                    frameErr_q <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parityErr_q <= ^{shiftReg_q, parityBit_q};
`endif
            end

            if (tick) begin
                tickCnt_q <= tickCnt_q + TICK_ONE;
                case (state_q)
                    IDLE: begin
                        if (!rxSync_q) begin
                            state_q   <= START;
                            tickCnt_q <= '0;
                        end
                    end

                    // A start bit that is no longer low at mid-bit is a glitch
                    START: begin
                        if (tickCnt_q == TICK_MID) begin
                            tickCnt_q <= '0;
                            bitCnt_q  <= '0;
                            state_q   <= rxSync_q ? IDLE : DATA;
                        end
                    end

                    // Entry happens mid start bit, so the sample point each
                    // full bit period later lands in the middle of each
                    // data bit.
                    DATA: begin
                        if (tickCnt_q == TICK_LAST) begin
                            shiftReg_q <= shiftReg_d;
                            if (bitCnt_q == BIT_LAST) begin
                                bitCnt_q  <= '0;
                                tickCnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q   <= PARITY;
`else
                                state_q   <= STOP;
`endif
                            end else begin
                                bitCnt_q <= bitCnt_q + BIT_ONE;
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tickCnt_q == TICK_LAST) begin
                            parityBit_q <= rxSync_q;
                            tickCnt_q   <= '0;
                            state_q     <= STOP;
                        end
                    end
`endif

                    // A low stop bit means a framing error or a line break.
                    // Either way the line must return high before another
                    // frame can start.
                    STOP: begin
                        if (tickCnt_q == TICK_LAST) begin
                            stopSeen_q <= 1'b1;
                            stopBit_q  <= rxSync_q;
                            tickCnt_q  <= '0;
                            state_q    <= rxSync_q ? IDLE : BREAK;
                        end
                    end

                    BREAK: begin
                        if (rxSync_q) begin
                            tickCnt_q <= '0;
                            state_q   <= IDLE;
                        end
                    end

                    default: begin
                        tickCnt_q <= '0;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed testbench for uart_rx with the default parameters (8 data bits,
// 16x oversampling).
//
// A free-running generator produces the active-low rx_clk pulse. The tick
// period starts at 65 clk for the first frame and is then shortened to keep
// the run brief. A negedge monitor counts output events. Each directed step
// compares those counts and the DUT outputs against hand-computed values.
// When UART_RX_PARITY_EN is defined, every frame carries an even-parity bit
// and the parity step is included.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_clk   = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tickDiv = 65;
    int tickCnt = 0;
    int errors  = 0;
    int checks  = 0;

    int         validRise  = 0;
    int         validHigh  = 0;
    int         frameErrs  = 0;
    int         overruns   = 0;
    int         parityErrs = 0;
    logic       prevValid  = 1'b0;
    logic [7:0] lastData   = 8'h00;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_clk     (rx_clk),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .overrun_err(overrun_err),
        .parity_err (parity_err)
`else
        .overrun_err(overrun_err)
`endif
    );

    // 10 MHz system clock
    always #50 clk = ~clk;

    // Sample-enable generator: one low clk out of every tickDiv clks
    always @(negedge clk) begin
        if (tickCnt >= tickDiv - 1) begin
            tickCnt = 0;
            rx_clk  = 1'b0;
        end else begin
            tickCnt = tickCnt + 1;
            rx_clk  = 1'b1;
        end
    end

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) validHigh = validHigh + 1;
        if (rx_valid && !prevValid) begin
            validRise = validRise + 1;
            lastData  = rx_data;
        end
        prevValid = rx_valid;
        if (frame_err)   frameErrs = frameErrs + 1;
        if (overrun_err) overruns  = overruns + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err)  parityErrs = parityErrs + 1;
`endif
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one frame, LSB first. The line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic parityBit);
        int bitClks;
        bitClks = OS * tickDiv;
        rx = 1'b0;
        waitClks(bitClks);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitClks(bitClks);
        end
`ifdef UART_RX_PARITY_EN
        rx = parityBit;
        waitClks(bitClks);
`else
        if (parityBit) rx = 1'b1;
`endif
        rx = stopBit;
        waitClks(bitClks);
    endtask

    initial begin
        int vr;
        int vh;
        int fe;
        int ov;
        int pe;

        // Reset state
        waitClks(5);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset overrun_err", overrun_err, 0);
        rst_n = 1'b1;
        waitClks(20);

        // Single byte at the nominal 65-clk tick period
        vr = validRise; vh = validHigh; fe = frameErrs; ov = overruns;
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        waitClks(200);
        checkOutput("t1 valid count", validRise, vr + 1);
        checkOutput("t1 rx_data", lastData, 8'hA5);
        checkOutput("t1 valid width", validHigh, vh + 1);
        checkOutput("t1 frame_err", frameErrs, fe);
        checkOutput("t1 overrun_err", overruns, ov);

        tickDiv = 16;
        waitClks(100);

        // Overrun: second byte arrives while the first is still unaccepted
        rx_ready = 1'b0;
        applyStimulus(8'h3C, 1'b1, ^8'h3C);
        waitClks(50);
        checkOutput("t2 first valid", rx_valid, 1);
        checkOutput("t2 first data", rx_data, 8'h3C);
        ov = overruns;
        applyStimulus(8'h81, 1'b1, ^8'h81);
        waitClks(50);
        checkOutput("t2 data held", rx_data, 8'h3C);
        checkOutput("t2 valid held", rx_valid, 1);
        checkOutput("t2 overrun pulses", overruns, ov + 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t2 valid after accept", rx_valid, 0);
        waitClks(10);

        // Framing error followed by a held-low line, then a good byte
        vr = validRise; fe = frameErrs;
        applyStimulus(8'h55, 1'b0, ^8'h55);
        waitClks(3 * OS * tickDiv);
        checkOutput("t3 frame_err pulses", frameErrs, fe + 1);
        checkOutput("t3 no valid in break", validRise, vr);
        rx = 1'b1;
        waitClks(2 * OS * tickDiv);
        checkOutput("t3 no valid after release", validRise, vr);
        applyStimulus(8'h0F, 1'b1, ^8'h0F);
        waitClks(50);
        checkOutput("t3 next data", lastData, 8'h0F);
        checkOutput("t3 next valid count", validRise, vr + 1);
        checkOutput("t3 frame_err total", frameErrs, fe + 1);

        // Start-bit glitch shorter than half a bit
        vr = validRise; fe = frameErrs; ov = overruns;
        rx = 1'b0;
        waitClks(4 * tickDiv);
        rx = 1'b1;
        waitClks(12 * OS * tickDiv);
        checkOutput("t4 glitch valid", validRise, vr);
        checkOutput("t4 glitch frame_err", frameErrs, fe);
        checkOutput("t4 glitch overrun", overruns, ov);

        // Reset in the middle of an all-ones byte, then a fresh byte
        vr = validRise;
        rx = 1'b0;
        waitClks(OS * tickDiv);
        rx = 1'b1;
        waitClks(3 * OS * tickDiv);
        rst_n = 1'b0;
        waitClks(3);
        checkOutput("t5 reset rx_data", rx_data, 0);
        checkOutput("t5 reset rx_valid", rx_valid, 0);
        checkOutput("t5 reset frame_err", frame_err, 0);
        checkOutput("t5 reset overrun_err", overrun_err, 0);
        rst_n = 1'b1;
        waitClks(7 * OS * tickDiv);
        applyStimulus(8'h12, 1'b1, ^8'h12);
        waitClks(50);
        checkOutput("t5 data", lastData, 8'h12);
        checkOutput("t5 valid count", validRise, vr + 1);

`ifdef UART_RX_PARITY_EN
        // Even parity: correct parity bit, then a wrong one
        vr = validRise; pe = parityErrs;
        applyStimulus(8'h07, 1'b1, 1'b1);
        waitClks(50);
        checkOutput("t6 good parity data", lastData, 8'h07);
        checkOutput("t6 good parity err", parityErrs, pe);
        applyStimulus(8'h07, 1'b1, 1'b0);
        waitClks(50);
        checkOutput("t6 bad parity data", lastData, 8'h07);
        checkOutput("t6 valid count", validRise, vr + 2);
        checkOutput("t6 bad parity err", parityErrs, pe + 1);
`else
        pe = parityErrs;
        checkOutput("no parity pulses", parityErrs, pe);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
